// File: rtl/decoder_sched.sv
// -----------------------------------------------------------------------------
// decoder_sched
// Round-robin scheduler that lets NREQ requesters share one fixed-latency
// decoder, with one transaction in flight at a time. A winning requester's
// 7-bit code is registered onto dec_code_o. The decoder result is sampled
// DEC_LAT cycles later and returned on a valid/ready response port tagged with
// the owner's index.
//
// Optional feature: define DECODER_SCHED_STATS_EN to add the 16-bit
// completed-transaction counter on txn_count_o.
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous, active-high reset
//   req_i          per-requester level request
//   code_i         requester k code in bits [7k+6:7k]
//   grant_o        one-hot, single-cycle pulse when a code is captured
//   dec_code_o     registered code presented to the shared decoder
//   dec_busy_o     high while a code is in flight in the decoder
//   dec_data_i     decoder result
//   resp_valid_o   response valid
//   resp_ready_i   response consumer ready
//   resp_id_o      zero-extended index of the response owner
//   resp_data_o    registered decoder result
//   txn_count_o    completed-transaction count (DECODER_SCHED_STATS_EN only)
// -----------------------------------------------------------------------------
module decoder_sched #(
  parameter int NREQ    = 4,
  parameter int DEC_W   = 8,
  parameter int DEC_LAT = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_i,
  input  logic [7*NREQ-1:0]    code_i,
  output logic [NREQ-1:0]      grant_o,
  output logic [6:0]           dec_code_o,
  output logic                 dec_busy_o,
  input  logic [DEC_W-1:0]     dec_data_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [2:0]           resp_id_o,
  output logic [DEC_W-1:0]     resp_data_o
`ifdef DECODER_SCHED_STATS_EN
  ,
  output logic [15:0]          txn_count_o
`endif
);

  localparam int IDX_W = (NREQ < 2) ? 1 : $clog2(NREQ);
  localparam int CNT_W = (DEC_LAT < 2) ? 1 : $clog2(DEC_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state_q;
  logic [NREQ-1:0]      grant_q;
  logic [6:0]           dec_code_q;
  logic                 busy_q;
  logic                 valid_q;
  logic [IDX_W-1:0]     id_q;
  logic [IDX_W-1:0]     last_q;
  logic [DEC_W-1:0]     data_q;
  logic [CNT_W-1:0]     cnt_q;
`ifdef DECODER_SCHED_STATS_EN
  logic [15:0]          txn_q;
`endif

  logic                 win_vld_d;
  logic [IDX_W-1:0]     win_idx_d;
  logic [NREQ-1:0]      grant_d;
  logic [6:0]           code_d;

  // Requester index reached by stepping 'off' positions past 'last', modulo NREQ.
  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] last, input int off);
    int s;
    s = int'(last) + off;
    if (s >= NREQ) begin
      s = s - NREQ;
    end else begin
      s = s;
    end
    return s[IDX_W-1:0];
  endfunction

  // Round-robin winner search: offsets 1..NREQ from the last completed owner, so
  // the previous owner is considered last and cannot starve anyone else.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    grant_d   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!win_vld_d && req_i[rr_idx(last_q, i)]) begin
        win_vld_d = 1'b1;
        win_idx_d = rr_idx(last_q, i);
      end else begin
        win_vld_d = win_vld_d;
      end
    end
    if (win_vld_d) begin
      grant_d[win_idx_d] = 1'b1;
    end else begin
      grant_d = '0;
    end
    code_d = code_i[7*win_idx_d +: 7];
  end

  // Scheduler FSM with all outputs registered; dec_code_q only loads on a grant
  // so the decoder input never moves outside a transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      dec_code_q <= 7'd0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      id_q       <= '0;
      last_q     <= IDX_W'(NREQ - 1);
      data_q     <= '0;
      cnt_q      <= '0;
`ifdef DECODER_SCHED_STATS_EN
      txn_q      <= 16'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          grant_q <= grant_d;
          if (win_vld_d) begin
            dec_code_q <= code_d;
            id_q       <= win_idx_d;
            cnt_q      <= CNT_W'(DEC_LAT);
            busy_q     <= 1'b1;
            state_q    <= WAIT;
          end else begin
            state_q    <= IDLE;
          end
        end
        WAIT: begin
          grant_q <= '0;
          cnt_q   <= cnt_q - 1'b1;
          // Counter value 1 marks the edge DEC_LAT cycles after dec_code_q changed.
          if (cnt_q == CNT_W'(1)) begin
            data_q  <= dec_data_i;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        RESP: begin
          grant_q <= '0;
          if (resp_ready_i) begin
            valid_q <= 1'b0;
            last_q  <= id_q;
            state_q <= IDLE;
`ifdef DECODER_SCHED_STATS_EN
            txn_q   <= txn_q + 16'd1;
`endif
          end else begin
            state_q <= RESP;
          end
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant_o      = grant_q;
  assign dec_code_o   = dec_code_q;
  assign dec_busy_o   = busy_q;
  assign resp_valid_o = valid_q;
  assign resp_id_o    = 3'(id_q);
  assign resp_data_o  = data_q;
`ifdef DECODER_SCHED_STATS_EN
  assign txn_count_o  = txn_q;
`endif

endmodule
